jk_reg_bank: RTL and testbench

- Parametrised bank of WIDTH independent JK-style storage bits, each with a runtime-selectable update mode: JK, SR, T or D.
- Each bit produces registered rise/fall pulses. The bank keeps a saturating count of update cycles in which any bit changed.
- Used as a control/status flag register: interrupt-style set/clear flags, toggle lines and sampled levels, with edge reporting to downstream logic.

---
 rtl/jk_reg_pkg.sv | 40 ++++
 rtl/jk_cell.sv | 46 ++++
 rtl/jk_reg_bank.sv | 64 ++++++
 tb/tb_jk_reg_bank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jk_reg_pkg.sv
// Shared types and next-state logic for the JK-style flag register bank.
// One function defines the update rule so every bit cell agrees on it.
package jk_reg_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK = 2'd0,
    JK_MODE_SR = 2'd1,
    JK_MODE_T  = 2'd2,
    JK_MODE_D  = 2'd3
  } jk_mode_t;

  // In SR mode, j=k=1 holds rather than being treated as an illegal input.
  function automatic logic jk_next(input jk_mode_t mode, input logic cur,
                                   input logic j, input logic k);
    logic n;
    n = cur;
    case (mode)
      JK_MODE_JK: begin
        case ({j, k})
          2'b11:   n = ~cur;
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          default: n = cur;
        endcase
      end
      JK_MODE_SR: begin
        case ({j, k})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          default: n = cur;
        endcase
      end
      JK_MODE_T: n = j ? ~cur : cur;
      JK_MODE_D: n = j;
      default:   n = cur;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One storage bit with registered rise/fall pulses.
// chg flags a combinational "this edge will change the bit" for the bank counter.
module jk_cell
  import jk_reg_pkg::*;
#(
  parameter logic POR_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     sclr,
  input  jk_mode_t mode,
  input  logic     j,
  input  logic     k,
  output logic     q,
  output logic     rise,
  output logic     fall,
  output logic     chg
);

  logic n;

  assign n   = jk_next(mode, q, j, k);
  assign chg = en & ~sclr & (n ^ q);

  // sclr-caused changes deliberately produce no edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= POR_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (sclr) begin
      q    <= POR_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (en) begin
      q    <= n;
      rise <= ~q & n;
      fall <= q & ~n;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK/SR/T/D flag bits with edge pulses and a saturating
// count of update edges in which at least one bit changed.
module jk_reg_bank
  import jk_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] POR_VALUE = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] chg;

  assign mode_e = jk_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell #(
      .POR_BIT (POR_VALUE[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sclr (sclr),
      .mode (mode_e),
      .j    (j[i]),
      .k    (k[i]),
      .q    (out[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .chg  (chg[i])
    );
  end

  // Pulses already encode |(out ^ n) from the last edge, so no extra flop.
  assign any_chg = |(rise | fall);

  // clr_cnt wins over an increment on the same edge; the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (clr_cnt) begin
      chg_cnt <= '0;
    end else if (|chg && chg_cnt != CNT_MAX) begin
      chg_cnt <= chg_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with WIDTH=4, POR_VALUE=4'b1010, CNT_W=2.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sclr;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic       clr_cnt;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_chg;
  logic [1:0] chg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(
    .WIDTH     (4),
    .POR_VALUE (4'b1010),
    .CNT_W     (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sclr    (sclr),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .clr_cnt (clr_cnt),
    .out     (out),
    .rise    (rise),
    .fall    (fall),
    .any_chg (any_chg),
    .chg_cnt (chg_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic s, input logic [1:0] m,
                       input logic [3:0] jv, input logic [3:0] kv, input logic cc);
    en = e; sclr = s; mode = m; j = jv; k = kv; clr_cnt = cc;
    tick();
  endtask

  task automatic check_all(input string name, input logic [3:0] e_out,
                           input logic [3:0] e_rise, input logic [3:0] e_fall,
                           input logic e_any, input logic [1:0] e_cnt);
    n_checks++;
    if (out !== e_out) begin
      n_fail++; $display("FAIL %s out: got %b expected %b", name, out, e_out);
    end
    n_checks++;
    if (rise !== e_rise) begin
      n_fail++; $display("FAIL %s rise: got %b expected %b", name, rise, e_rise);
    end
    n_checks++;
    if (fall !== e_fall) begin
      n_fail++; $display("FAIL %s fall: got %b expected %b", name, fall, e_fall);
    end
    n_checks++;
    if (any_chg !== e_any) begin
      n_fail++; $display("FAIL %s any_chg: got %b expected %b", name, any_chg, e_any);
    end
    n_checks++;
    if (chg_cnt !== e_cnt) begin
      n_fail++; $display("FAIL %s chg_cnt: got %0d expected %0d", name, chg_cnt, e_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; sclr = 0; mode = 2'd0; j = '0; k = '0; clr_cnt = 0;
    #2;
    check_all("reset_initial", 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick();
    @(negedge clk) rst = 1'b0;
    tick();
    check_all("reset_release", 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0);
    // D-mode load of 0000 changes bits 3 and 1
    drive(1, 0, 2'd3, 4'b0000, 4'b0000, 0);
    check_all("pre_rst_update", 4'b0000, 4'b0000, 4'b1010, 1'b1, 2'd1);
    en = 0;
    #3 rst = 1'b1;
    #1;
    check_all("rst_async", 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick();
    @(negedge clk) rst = 1'b0;
    tick();
    check_all("rst_no_pulse", 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0);
  endtask

  task automatic test_jk();
    // bit3 toggle, bit2 set, bit1 clear, bit0 hold
    drive(1, 0, 2'd0, 4'b1100, 4'b1010, 0);
    check_all("jk", 4'b0100, 4'b0100, 4'b1010, 1'b1, 2'd1);
  endtask

  task automatic test_sr_hold();
    drive(1, 0, 2'd1, 4'b1111, 4'b1111, 0);
    check_all("sr_both_high", 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1);
    drive(1, 0, 2'd1, 4'b0001, 4'b0100, 0);
    check_all("sr_set_clr", 4'b0001, 4'b0001, 4'b0100, 1'b1, 2'd2);
  endtask

  task automatic test_sclr();
    drive(1, 1, 2'd3, 4'b1111, 4'b0000, 0);
    check_all("sclr", 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd2);
  endtask

  task automatic test_clr_priority();
    drive(1, 0, 2'd3, 4'b0000, 4'b0000, 1);
    check_all("clr_cnt_priority", 4'b0000, 4'b0000, 4'b1010, 1'b1, 2'd0);
  endtask

  task automatic test_t_d_en();
    drive(1, 0, 2'd2, 4'b0001, 4'b0000, 0);
    check_all("t_edge1", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd1);
    drive(1, 0, 2'd2, 4'b0001, 4'b0000, 0);
    check_all("t_edge2", 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd2);
    drive(1, 0, 2'd2, 4'b0001, 4'b0000, 0);
    check_all("t_edge3", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd3);
    drive(1, 0, 2'd2, 4'b0001, 4'b0000, 0);
    check_all("t_saturate", 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd3);
    drive(0, 0, 2'd3, 4'b0110, 4'b1111, 0);
    check_all("d_en_low", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3);
    drive(1, 0, 2'd3, 4'b0110, 4'b1111, 0);
    check_all("d_en_high", 4'b0110, 4'b0110, 4'b0000, 1'b1, 2'd3);
    drive(0, 0, 2'd3, 4'b0000, 4'b0000, 1);
    check_all("clr_cnt_idle", 4'b0110, 4'b0000, 4'b0000, 1'b0, 2'd0);
  endtask

  initial begin
    test_reset();
    test_jk();
    test_sr_hold();
    test_sclr();
    test_clr_priority();
    test_t_d_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
